// File: rtl/load_value_verify.sv
// Verifies value-predicted loads in program order against the data memory returns; a wrong
// prediction writes back the real value and requests a checkpoint restore. Optional predictor
// training outputs are added when LOAD_VALUE_VERIFY_TRAIN_EN is defined.
module load_value_verify #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int CHECKPOINT_WIDTH = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int FREE_LIST_WIDTH  = 5,
    parameter int QUEUE_DEPTH      = 4,
    parameter int RECOVER_CYCLES   = 2
) (
    input  logic                            i_Clk,
    input  logic                            i_Reset_n,
    input  logic                            i_Issue_Valid,
    input  logic [ADDRESS_WIDTH-1:0]        i_PC,
    input  logic [CHECKPOINT_WIDTH-1:0]     i_Checkpoint,
    input  logic [DATA_WIDTH-1:0]           i_Pred_Data,
    input  logic [REG_ADDR_WIDTH:0]         i_PWrite_Addr,
    input  logic [FREE_LIST_WIDTH-1:0]      i_Phys_Active_List_Index,
    output logic                            o_Issue_Ready,
    input  logic                            i_Mem_Done,
    input  logic [DATA_WIDTH-1:0]           i_Mem_Data,
    output logic                            o_Verify_Valid,
    output logic                            o_Verify_Ok,
    output logic                            o_Mispredict,
    output logic [CHECKPOINT_WIDTH-1:0]     o_Restore_Checkpoint,
    output logic [ADDRESS_WIDTH-1:0]        o_Restore_PC,
    output logic                            o_Writes_Back,
    output logic [DATA_WIDTH-1:0]           o_WriteBack_Data,
    output logic [REG_ADDR_WIDTH:0]         o_PWrite_Addr,
    output logic [FREE_LIST_WIDTH-1:0]      o_Phys_Active_List_Index,
    output logic [$clog2(QUEUE_DEPTH):0]    o_Count,
    output logic                            o_Error
`ifdef LOAD_VALUE_VERIFY_TRAIN_EN
    ,
    output logic                            o_Train_Valid,
    output logic [ADDRESS_WIDTH-1:0]        o_Train_PC,
    output logic [DATA_WIDTH-1:0]           o_Train_Data,
    output logic                            o_Train_Hit
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RC_W  = $clog2(RECOVER_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(QUEUE_DEPTH);
    localparam logic [RC_W-1:0]  RC_LAST_C = RC_W'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRACK   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [RC_W-1:0] rc, rc_nxt;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic [ADDRESS_WIDTH-1:0]    q_pc   [QUEUE_DEPTH];
    logic [CHECKPOINT_WIDTH-1:0] q_ckpt [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]       q_pred [QUEUE_DEPTH];
    logic [REG_ADDR_WIDTH:0]     q_pa   [QUEUE_DEPTH];
    logic [FREE_LIST_WIDTH-1:0]  q_ali  [QUEUE_DEPTH];

    logic [ADDRESS_WIDTH-1:0]    head_pc_p0;
    logic [CHECKPOINT_WIDTH-1:0] head_ckpt_p0;
    logic [DATA_WIDTH-1:0]       head_pred_p0;
    logic [REG_ADDR_WIDTH:0]     head_pa_p0;
    logic [FREE_LIST_WIDTH-1:0]  head_ali_p0;

    logic in_recover, full;
    logic pop_p0, match_p0, mis_p0, push_p0, err_p0;

    logic                        vld_p1, ok_p1, mis_p1, wb_p1, err_p1;
    logic [CHECKPOINT_WIDTH-1:0] ckpt_p1;
    logic [ADDRESS_WIDTH-1:0]    pc_p1;
    logic [DATA_WIDTH-1:0]       wb_data_p1;
    logic [REG_ADDR_WIDTH:0]     pa_p1;
    logic [FREE_LIST_WIDTH-1:0]  ali_p1;

    // Stage p0: head lookup, compare and queue control
    assign head_pc_p0   = q_pc[rd_ptr];
    assign head_ckpt_p0 = q_ckpt[rd_ptr];
    assign head_pred_p0 = q_pred[rd_ptr];
    assign head_pa_p0   = q_pa[rd_ptr];
    assign head_ali_p0  = q_ali[rd_ptr];

    assign in_recover = (state == ST_RECOVER);
    assign full       = (count == DEPTH_C);
    assign pop_p0     = i_Mem_Done && (state == ST_TRACK);
    assign match_p0   = (i_Mem_Data == head_pred_p0);
    assign mis_p0     = pop_p0 && !match_p0;
    assign err_p0     = i_Mem_Done && (state == ST_IDLE);
    // A push into a full queue rides on the pop of the same cycle; a flush drops it.
    assign push_p0    = i_Issue_Valid && !in_recover && !mis_p0 && (!full || pop_p0);

    assign o_Issue_Ready = !full && !in_recover;

    always_comb begin
        state_nxt = state;
        rc_nxt    = rc;
        case (state)
            ST_IDLE: begin
                if (push_p0) state_nxt = ST_TRACK;
            end
            ST_TRACK: begin
                if (mis_p0) begin
                    state_nxt = ST_RECOVER;
                    rc_nxt    = '0;
                end else if (pop_p0 && !push_p0 && (count == CNT_W'(1))) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RECOVER: begin
                if (rc == RC_LAST_C) state_nxt = ST_IDLE;
                else                 rc_nxt    = rc + RC_W'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state <= ST_IDLE;
            rc    <= '0;
        end else begin
            state <= state_nxt;
            rc    <= rc_nxt;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mis_p0) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push_p0) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_p0)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_p0, pop_p0})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (push_p0) begin
            q_pc[wr_ptr]   <= i_PC;
            q_ckpt[wr_ptr] <= i_Checkpoint;
            q_pred[wr_ptr] <= i_Pred_Data;
            q_pa[wr_ptr]   <= i_PWrite_Addr;
            q_ali[wr_ptr]  <= i_Phys_Active_List_Index;
        end
    end

    // Stage p1: registered verification results
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            vld_p1     <= 1'b0;
            ok_p1      <= 1'b0;
            mis_p1     <= 1'b0;
            wb_p1      <= 1'b0;
            err_p1     <= 1'b0;
            ckpt_p1    <= '0;
            pc_p1      <= '0;
            wb_data_p1 <= '0;
            pa_p1      <= '0;
            ali_p1     <= '0;
        end else begin
            vld_p1 <= pop_p0;
            ok_p1  <= pop_p0 && match_p0;
            mis_p1 <= mis_p0;
            wb_p1  <= mis_p0;
            err_p1 <= err_p1 || err_p0;
            if (pop_p0) ali_p1 <= head_ali_p0;
            if (mis_p0) begin
                ckpt_p1    <= head_ckpt_p0;
                pc_p1      <= head_pc_p0;
                wb_data_p1 <= i_Mem_Data;
                pa_p1      <= head_pa_p0;
            end
        end
    end

    assign o_Verify_Valid           = vld_p1;
    assign o_Verify_Ok              = ok_p1;
    assign o_Mispredict             = mis_p1;
    assign o_Writes_Back            = wb_p1;
    assign o_Error                  = err_p1;
    assign o_Restore_Checkpoint     = ckpt_p1;
    assign o_Restore_PC             = pc_p1;
    assign o_WriteBack_Data         = wb_data_p1;
    assign o_PWrite_Addr            = pa_p1;
    assign o_Phys_Active_List_Index = ali_p1;
    assign o_Count                  = count;

`ifdef LOAD_VALUE_VERIFY_TRAIN_EN
    logic                     tr_vld_p1, tr_hit_p1;
    logic [ADDRESS_WIDTH-1:0] tr_pc_p1;
    logic [DATA_WIDTH-1:0]    tr_data_p1;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            tr_vld_p1  <= 1'b0;
            tr_hit_p1  <= 1'b0;
            tr_pc_p1   <= '0;
            tr_data_p1 <= '0;
        end else begin
            tr_vld_p1 <= pop_p0;
            if (pop_p0) begin
                tr_hit_p1  <= match_p0;
                tr_pc_p1   <= head_pc_p0;
                tr_data_p1 <= i_Mem_Data;
            end
        end
    end

    assign o_Train_Valid = tr_vld_p1;
    assign o_Train_PC    = tr_pc_p1;
    assign o_Train_Data  = tr_data_p1;
    assign o_Train_Hit   = tr_hit_p1;
`endif

endmodule

// File: tb/tb_load_value_verify.sv
// Bench for load_value_verify: directed scenarios plus random traffic checked against a
// queue-based model of in-order verification with flush-and-recover on a wrong prediction.
module tb_load_value_verify;

    localparam int DEPTH = 4;
    localparam int RCY   = 2;

    logic        clk = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_Issue_Valid = 1'b0;
    logic [31:0] i_PC = '0;
    logic [1:0]  i_Checkpoint = '0;
    logic [31:0] i_Pred_Data = '0;
    logic [5:0]  i_PWrite_Addr = '0;
    logic [4:0]  i_Phys_Active_List_Index = '0;
    logic        i_Mem_Done = 1'b0;
    logic [31:0] i_Mem_Data = '0;

    logic        o_Issue_Ready, o_Verify_Valid, o_Verify_Ok, o_Mispredict, o_Writes_Back, o_Error;
    logic [1:0]  o_Restore_Checkpoint;
    logic [31:0] o_Restore_PC, o_WriteBack_Data;
    logic [5:0]  o_PWrite_Addr;
    logic [4:0]  o_Phys_Active_List_Index;
    logic [2:0]  o_Count;
`ifdef LOAD_VALUE_VERIFY_TRAIN_EN
    logic        o_Train_Valid, o_Train_Hit;
    logic [31:0] o_Train_PC, o_Train_Data;
`endif

    load_value_verify dut (
        .i_Clk                    (clk),
        .i_Reset_n                (i_Reset_n),
        .i_Issue_Valid            (i_Issue_Valid),
        .i_PC                     (i_PC),
        .i_Checkpoint             (i_Checkpoint),
        .i_Pred_Data              (i_Pred_Data),
        .i_PWrite_Addr            (i_PWrite_Addr),
        .i_Phys_Active_List_Index (i_Phys_Active_List_Index),
        .o_Issue_Ready            (o_Issue_Ready),
        .i_Mem_Done               (i_Mem_Done),
        .i_Mem_Data               (i_Mem_Data),
        .o_Verify_Valid           (o_Verify_Valid),
        .o_Verify_Ok              (o_Verify_Ok),
        .o_Mispredict             (o_Mispredict),
        .o_Restore_Checkpoint     (o_Restore_Checkpoint),
        .o_Restore_PC             (o_Restore_PC),
        .o_Writes_Back            (o_Writes_Back),
        .o_WriteBack_Data         (o_WriteBack_Data),
        .o_PWrite_Addr            (o_PWrite_Addr),
        .o_Phys_Active_List_Index (o_Phys_Active_List_Index),
        .o_Count                  (o_Count),
        .o_Error                  (o_Error)
`ifdef LOAD_VALUE_VERIFY_TRAIN_EN
        ,
        .o_Train_Valid            (o_Train_Valid),
        .o_Train_PC               (o_Train_PC),
        .o_Train_Data             (o_Train_Data),
        .o_Train_Hit              (o_Train_Hit)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  ck;
        logic [31:0] pred;
        logic [5:0]  pa;
        logic [4:0]  ali;
    } ent_t;

    ent_t mq[$];
    int   rl;
    int   tests = 0;
    int   fails = 0;

    logic        e_vld, e_ok, e_mis, e_wb, e_err;
    logic [1:0]  e_rck;
    logic [31:0] e_rpc, e_wbd;
    logic [5:0]  e_pa;
    logic [4:0]  e_ali;
    logic        e_tv, e_th;
    logic [31:0] e_tpc, e_td;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rl = 0;
        {e_vld, e_ok, e_mis, e_wb, e_err, e_tv, e_th} = '0;
        e_rck = '0; e_rpc = '0; e_wbd = '0; e_pa = '0; e_ali = '0; e_tpc = '0; e_td = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".vld"},   o_Verify_Valid, e_vld);
        chk({tag, ".ok"},    o_Verify_Ok, e_ok);
        chk({tag, ".mis"},   o_Mispredict, e_mis);
        chk({tag, ".wb"},    o_Writes_Back, e_wb);
        chk({tag, ".err"},   o_Error, e_err);
        chk({tag, ".count"}, o_Count, mq.size());
        chk({tag, ".ready"}, o_Issue_Ready, (mq.size() < DEPTH) && (rl == 0));
        chk({tag, ".rpc"},   o_Restore_PC, e_rpc);
        chk({tag, ".rck"},   o_Restore_Checkpoint, e_rck);
        chk({tag, ".wbd"},   o_WriteBack_Data, e_wbd);
        chk({tag, ".pa"},    o_PWrite_Addr, e_pa);
        chk({tag, ".ali"},   o_Phys_Active_List_Index, e_ali);
`ifdef LOAD_VALUE_VERIFY_TRAIN_EN
        chk({tag, ".tv"},    o_Train_Valid, e_tv);
        chk({tag, ".tpc"},   o_Train_PC, e_tpc);
        chk({tag, ".td"},    o_Train_Data, e_td);
        chk({tag, ".th"},    o_Train_Hit, e_th);
`endif
    endtask

    // One clock: drive inputs, predict the outcome, then compare after the edge.
    task automatic step(input bit iv, input logic [31:0] pc, input logic [1:0] ck,
                        input logic [31:0] pred, input logic [5:0] pa, input logic [4:0] ali,
                        input bit md, input logic [31:0] mdata, input string tag);
        bit   in_rec, pop, errev, match, mis, push;
        ent_t head, ne;
        i_Issue_Valid = iv; i_PC = pc; i_Checkpoint = ck; i_Pred_Data = pred;
        i_PWrite_Addr = pa; i_Phys_Active_List_Index = ali;
        i_Mem_Done = md; i_Mem_Data = mdata;
        in_rec = (rl > 0);
        pop    = md && !in_rec && (mq.size() > 0);
        errev  = md && !in_rec && (mq.size() == 0);
        if (pop) head = mq[0];
        match  = pop && (head.pred == mdata);
        mis    = pop && !match;
        push   = iv && !in_rec && !mis && ((mq.size() < DEPTH) || pop);
        ne = '{pc: pc, ck: ck, pred: pred, pa: pa, ali: ali};
        @(posedge clk);
        #1;
        i_Issue_Valid = 1'b0; i_Mem_Done = 1'b0;
        e_vld = pop; e_ok = match; e_mis = mis; e_wb = mis; e_tv = pop;
        if (pop) begin
            e_ali = head.ali; e_tpc = head.pc; e_td = mdata; e_th = match;
        end
        if (mis) begin
            e_rpc = head.pc; e_rck = head.ck; e_wbd = mdata; e_pa = head.pa;
        end
        if (errev) e_err = 1'b1;
        if (in_rec) rl--;
        if (mis) begin
            mq.delete();
            rl = RCY;
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(ne);
        end
        check_all(tag);
    endtask

    task automatic do_reset(input bit iv, input bit md, input string tag);
        i_Reset_n = 1'b0; i_Issue_Valid = iv; i_Mem_Done = md;
        @(posedge clk);
        #1;
        i_Reset_n = 1'b1; i_Issue_Valid = 1'b0; i_Mem_Done = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(0, 32'h0, 2'd0, 32'h0, 6'd0, 5'd0, 0, 32'h0, tag);
    endtask

    initial begin
        logic [31:0] md_data;
        model_reset();
        do_reset(0, 0, "rst0");
        do_reset(1, 1, "rst1");

        // Correct prediction retires silently
        step(1, 32'h100, 2'd1, 32'h5, 6'd10, 5'd3, 0, 32'h0, "t1_push");
        step(0, 32'h0, 2'd0, 32'h0, 6'd0, 5'd0, 1, 32'h5, "t1_done");
        chk("t1_vld", o_Verify_Valid, 1);
        chk("t1_ok", o_Verify_Ok, 1);
        chk("t1_wb", o_Writes_Back, 0);
        chk("t1_cnt", o_Count, 0);
        idle("t1_idle");

        // Wrong prediction on the head of three, with a same-cycle push that must be dropped
        step(1, 32'h200, 2'd2, 32'h11, 6'd33, 5'd7, 0, 32'h0, "t2_p0");
        step(1, 32'h204, 2'd3, 32'h22, 6'd34, 5'd8, 0, 32'h0, "t2_p1");
        step(1, 32'h208, 2'd0, 32'h33, 6'd35, 5'd9, 0, 32'h0, "t2_p2");
        step(1, 32'h20c, 2'd1, 32'h44, 6'd36, 5'd10, 1, 32'h99, "t2_mis");
        chk("t2_mis", o_Mispredict, 1);
        chk("t2_rpc", o_Restore_PC, 32'h200);
        chk("t2_wb", o_Writes_Back, 1);
        chk("t2_wbd", o_WriteBack_Data, 32'h99);
        chk("t2_cnt", o_Count, 0);
        chk("t2_rdy0", o_Issue_Ready, 0);
`ifdef LOAD_VALUE_VERIFY_TRAIN_EN
        chk("t2_tv", o_Train_Valid, 1);
        chk("t2_tpc", o_Train_PC, 32'h200);
        chk("t2_th", o_Train_Hit, 0);
`endif
        step(1, 32'h300, 2'd0, 32'h1, 6'd1, 5'd1, 1, 32'h1, "t2_rec1");
        chk("t2_rdy1", o_Issue_Ready, 0);
        chk("t2_recvld", o_Verify_Valid, 0);
        idle("t2_rec2");
        chk("t2_rdy2", o_Issue_Ready, 1);

        // Fill, then push+pop at full across pointer wrap
        for (int i = 0; i < DEPTH; i++)
            step(1, 32'h400 + 32'(i * 4), 2'(i), 32'h1000 + 32'(i), 6'(i), 5'(i), 0, 32'h0, "t3_fill");
        chk("t3_full_rdy", o_Issue_Ready, 0);
        step(1, 32'h4f0, 2'd0, 32'h77, 6'd1, 5'd1, 0, 32'h0, "t3_rej");
        for (int i = 0; i < 10; i++) begin
            md_data = mq[0].pred;
            step(1, 32'h500 + 32'(i * 4), 2'(i), 32'h2000 + 32'(i), 6'(i + 20), 5'(i + 11), 1, md_data, "t3_wrap");
            chk("t3_cnt4", o_Count, 4);
        end
        while (mq.size() > 0) begin
            md_data = mq[0].pred;
            step(0, 32'h0, 2'd0, 32'h0, 6'd0, 5'd0, 1, md_data, "t3_drain");
        end

        // Mem_Done with nothing outstanding
        step(0, 32'h0, 2'd0, 32'h0, 6'd0, 5'd0, 1, 32'h5, "t4_empty");
        chk("t4_err", o_Error, 1);
        chk("t4_novld", o_Verify_Valid, 0);
        idle("t4_hold");
        chk("t4_errhold", o_Error, 1);

        // Reset while recovering, with pushes attempted during recovery
        step(1, 32'h600, 2'd1, 32'hA, 6'd2, 5'd2, 0, 32'h0, "t5_p0");
        step(1, 32'h604, 2'd2, 32'hB, 6'd3, 5'd3, 0, 32'h0, "t5_p1");
        step(0, 32'h0, 2'd0, 32'h0, 6'd0, 5'd0, 1, 32'hBAD, "t5_mis");
        step(1, 32'h608, 2'd3, 32'hC, 6'd4, 5'd4, 0, 32'h0, "t5_rec");
        do_reset(1, 1, "t5_rst");
        chk("t5_rdy", o_Issue_Ready, 1);
        chk("t5_err", o_Error, 0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset($urandom_range(0, 1), $urandom_range(0, 1), "rnd_rst");
            end else begin
                if (mq.size() > 0 && $urandom_range(0, 4) != 0) md_data = mq[0].pred;
                else md_data = $urandom;
                step($urandom_range(0, 9) < 6, $urandom, 2'($urandom), $urandom_range(0, 3),
                     6'($urandom), 5'($urandom), $urandom_range(0, 9) < 4, md_data, "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
